// File: rtl/cpu_reg_bank_if.sv
// Command/read-port bundle for cpu_reg_bank: register loads, SP inc/dec,
// the three read ports and the two status pulses.
interface cpu_reg_bank_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_REGS = 4
);
  localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic             load_en;
  logic [SEL_W-1:0] load_sel;
  logic [WIDTH-1:0] load_data;
  logic             sp_inc;
  logic             sp_dec;
  logic             sb_en;
  logic [SEL_W-1:0] sb_sel;
  logic             db_en;
  logic [SEL_W-1:0] db_sel;
  logic             adl_en;
  logic [WIDTH-1:0] sb_out;
  logic [WIDTH-1:0] db_out;
  logic [WIDTH-1:0] adl_out;
  logic             sp_wrap;
  logic             conflict;

  modport master (
    output load_en, load_sel, load_data, sp_inc, sp_dec,
    output sb_en, sb_sel, db_en, db_sel, adl_en,
    input  sb_out, db_out, adl_out, sp_wrap, conflict
  );

  modport slave (
    input  load_en, load_sel, load_data, sp_inc, sp_dec,
    input  sb_en, sb_sel, db_en, db_sel, adl_en,
    output sb_out, db_out, adl_out, sp_wrap, conflict
  );
endinterface

// File: rtl/cpu_reg_bank.sv
// Edge-triggered bank of CPU programmer registers (A, X, Y, S by default) with
// stack-pointer inc/dec, wrap and illegal-command pulses, and three read ports.
module cpu_reg_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      NUM_REGS  = 4,
  parameter int unsigned      SP_INDEX  = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] SP_RESET  = WIDTH'('hFF)
) (
  input logic           clk,
  input logic           rst,
  cpu_reg_bank_if.slave bus
);

  localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic             wrap_q, wrap_d;
  logic             conflict_q, conflict_d;

  logic             load_ok;
  logic             sp_load;
  logic             inc_only;
  logic             dec_only;
  logic [WIDTH-1:0] sp_cur;

  assign sp_cur   = regs_q[SP_INDEX];
  assign load_ok  = bus.load_en && (32'(bus.load_sel) < NUM_REGS);
  assign sp_load  = load_ok && (32'(bus.load_sel) == SP_INDEX);
  assign inc_only = bus.sp_inc && !bus.sp_dec;
  assign dec_only = bus.sp_dec && !bus.sp_inc;

  // Next-state: load beats inc/dec on SP; inc+dec together leaves SP alone.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    wrap_d = 1'b0;

    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (load_ok && (32'(bus.load_sel) == i)) begin
        regs_d[i] = bus.load_data;
      end
    end

    if (!sp_load) begin
      if (inc_only) begin
        regs_d[SP_INDEX] = sp_cur + 1'b1;
        wrap_d           = (sp_cur == '1);
      end else if (dec_only) begin
        regs_d[SP_INDEX] = sp_cur - 1'b1;
        wrap_d           = (sp_cur == '0);
      end
    end

    conflict_d = (bus.sp_inc && bus.sp_dec)
              || (bus.load_en && !load_ok)
              || (sp_load && (bus.sp_inc || bus.sp_dec));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? SP_RESET : RESET_VAL;
      end
      wrap_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wrap_q     <= wrap_d;
      conflict_q <= conflict_d;
    end
  end

  // Read ports are zero when disabled or when the select is out of range.
  always_comb begin
    bus.sb_out = '0;
    bus.db_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (bus.sb_en && (32'(bus.sb_sel) == i)) begin
        bus.sb_out = regs_q[i];
      end
      if (bus.db_en && (32'(bus.db_sel) == i)) begin
        bus.db_out = regs_q[i];
      end
    end
  end

  assign bus.adl_out  = bus.adl_en ? sp_cur : '0;
  assign bus.sp_wrap  = wrap_q;
  assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_cpu_reg_bank.sv
// Bench for cpu_reg_bank: default bank checked every cycle against a reference
// model under random commands, plus directed 3-register and 16-bit instances.
module tb_cpu_reg_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cpu_reg_bank_if #(.WIDTH(8),  .NUM_REGS(4)) if0 ();
  cpu_reg_bank_if #(.WIDTH(8),  .NUM_REGS(3)) if1 ();
  cpu_reg_bank_if #(.WIDTH(16), .NUM_REGS(4)) if2 ();

  cpu_reg_bank #(.WIDTH(8), .NUM_REGS(4), .SP_INDEX(3)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  cpu_reg_bank #(.WIDTH(8), .NUM_REGS(3), .SP_INDEX(2)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  cpu_reg_bank #(.WIDTH(16), .NUM_REGS(4), .SP_INDEX(3), .SP_RESET(16'h01FF)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  // Reference model of the default bank: A, X, Y, S as plain integers.
  int unsigned m_regs [4];
  bit          m_wrap;
  bit          m_conflict;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_regs     = '{0, 0, 0, 255};
    m_wrap     = 1'b0;
    m_conflict = 1'b0;
  endtask

  task automatic model_step();
    int unsigned sel = int'(if0.load_sel);
    int unsigned sp  = m_regs[3];
    bit          ld  = if0.load_en;
    bit          inc = if0.sp_inc;
    bit          dec = if0.sp_dec;
    bit          ld_sp = ld && sel == 3;
    m_conflict = (inc && dec) || (ld && sel >= 4) || (ld_sp && (inc || dec));
    m_wrap     = 1'b0;
    if (ld && sel < 4) m_regs[sel] = int'(if0.load_data);
    if (!ld_sp && inc && !dec) begin
      m_wrap    = (sp == 255);
      m_regs[3] = (sp + 1) % 256;
    end else if (!ld_sp && dec && !inc) begin
      m_wrap    = (sp == 0);
      m_regs[3] = (sp + 255) % 256;
    end
  endtask

  function automatic int unsigned m_read(input bit en, input int unsigned sel);
    return (en && sel < 4) ? m_regs[sel] : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_all();
    {if0.load_en, if0.load_sel, if0.load_data, if0.sp_inc, if0.sp_dec} = '0;
    {if0.sb_en, if0.sb_sel, if0.db_en, if0.db_sel, if0.adl_en} = '0;
    {if1.load_en, if1.load_sel, if1.load_data, if1.sp_inc, if1.sp_dec} = '0;
    {if1.sb_en, if1.sb_sel, if1.db_en, if1.db_sel, if1.adl_en} = '0;
    {if2.load_en, if2.load_sel, if2.load_data, if2.sp_inc, if2.sp_dec} = '0;
    {if2.sb_en, if2.sb_sel, if2.db_en, if2.db_sel, if2.adl_en} = '0;
  endtask

  task automatic load0(input int unsigned sel, input int unsigned data);
    if0.load_en   = 1'b1;
    if0.load_sel  = 2'(sel);
    if0.load_data = 8'(data);
    step();
    if0.load_en   = 1'b0;
  endtask

  // Every-cycle compare of the default bank against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("sb_out",   32'(if0.sb_out),   m_read(if0.sb_en, int'(if0.sb_sel)));
      chk("db_out",   32'(if0.db_out),   m_read(if0.db_en, int'(if0.db_sel)));
      chk("adl_out",  32'(if0.adl_out),  if0.adl_en ? m_regs[3] : 0);
      chk("sp_wrap",  32'(if0.sp_wrap),  32'(m_wrap));
      chk("conflict", 32'(if0.conflict), 32'(m_conflict));
    end
  end

  initial begin
    idle_all();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Async reset mid-cycle after dirtying every register and the conflict flag.
    load0(0, 8'h33);
    load0(1, 8'h44);
    load0(2, 8'h55);
    if0.sp_dec = 1'b1;
    step();
    if0.sp_dec = 1'b0;
    {if0.sp_inc, if0.sp_dec} = 2'b11;
    step();
    {if0.sp_inc, if0.sp_dec} = 2'b00;
    if0.sb_en = 1'b1; if0.sb_sel = 2'd0;
    if0.db_en = 1'b1; if0.db_sel = 2'd1;
    if0.adl_en = 1'b1;
    #1 chk("pre_rst_conflict", 32'(if0.conflict), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_a", 32'(if0.sb_out), 32'h00);
    chk("rst_x", 32'(if0.db_out), 32'h00);
    chk("rst_s", 32'(if0.adl_out), 32'hFF);
    chk("rst_wrap", 32'(if0.sp_wrap), 32'h0);
    chk("rst_conflict", 32'(if0.conflict), 32'h0);
    if0.sb_sel = 2'd2;
    #1 chk("rst_y", 32'(if0.sb_out), 32'h00);
    rst = 1'b0;
    model_reset();
    idle_all();

    // Load X and read it back: old value during the load cycle, new one after.
    if0.load_en = 1'b1; if0.load_sel = 2'd1; if0.load_data = 8'h5A;
    if0.sb_en = 1'b1; if0.sb_sel = 2'd1;
    if0.db_en = 1'b1; if0.db_sel = 2'd1;
    #1;
    chk("rbw_sb", 32'(if0.sb_out), 32'h00);
    chk("rbw_db", 32'(if0.db_out), 32'h00);
    step();
    if0.load_en = 1'b0;
    chk("load_sb", 32'(if0.sb_out), 32'h5A);
    chk("load_db", 32'(if0.db_out), 32'h5A);
    if0.sb_en = 1'b0;
    #1 chk("sb_disabled", 32'(if0.sb_out), 32'h00);

    // SP wrap in both directions.
    if0.adl_en = 1'b1;
    if0.sp_inc = 1'b1;
    step();
    if0.sp_inc = 1'b0;
    chk("inc_wrap_s", 32'(if0.adl_out), 32'h00);
    chk("inc_wrap", 32'(if0.sp_wrap), 32'h1);
    step();
    chk("wrap_pulse_end", 32'(if0.sp_wrap), 32'h0);
    if0.sp_dec = 1'b1;
    step();
    if0.sp_dec = 1'b0;
    chk("dec_wrap_s", 32'(if0.adl_out), 32'hFF);
    chk("dec_wrap", 32'(if0.sp_wrap), 32'h1);

    // Load to S beats DEC; INC+DEC holds S.
    load0(3, 8'h10);
    if0.load_en = 1'b1; if0.load_sel = 2'd3; if0.load_data = 8'h80; if0.sp_dec = 1'b1;
    step();
    if0.load_en = 1'b0; if0.sp_dec = 1'b0;
    chk("prio_s", 32'(if0.adl_out), 32'h80);
    chk("prio_conflict", 32'(if0.conflict), 32'h1);
    chk("prio_wrap", 32'(if0.sp_wrap), 32'h0);
    {if0.sp_inc, if0.sp_dec} = 2'b11;
    step();
    {if0.sp_inc, if0.sp_dec} = 2'b00;
    chk("incdec_s", 32'(if0.adl_out), 32'h80);
    chk("incdec_conflict", 32'(if0.conflict), 32'h1);
    step();
    chk("conflict_pulse_end", 32'(if0.conflict), 32'h0);

    // Random commands, biased toward SP values next to the wrap points.
    for (int n = 0; n < 3000; n++) begin
      int unsigned pick = $urandom_range(0, 7);
      if0.load_en   = ($urandom_range(0, 2) == 0);
      if0.load_sel  = 2'($urandom_range(0, 3));
      if0.load_data = (pick < 2) ? 8'((pick == 0) ? 8'hFF : 8'h00) : 8'($urandom);
      if0.sp_inc    = ($urandom_range(0, 2) == 0);
      if0.sp_dec    = ($urandom_range(0, 2) == 0);
      if0.sb_en     = 1'($urandom);
      if0.sb_sel    = 2'($urandom);
      if0.db_en     = 1'($urandom);
      if0.db_sel    = 2'($urandom);
      if0.adl_en    = 1'($urandom);
      step();
    end
    idle_all();
    step();

    // Three-register bank: select 3 is illegal for writes and reads.
    if1.load_en = 1'b1; if1.load_sel = 2'd0; if1.load_data = 8'h11;
    step();
    if1.load_sel = 2'd3; if1.load_data = 8'h77;
    step();
    if1.load_en = 1'b0;
    chk("bad_conflict", 32'(if1.conflict), 32'h1);
    if1.sb_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_tbl [4];
      exp_tbl = '{8'h11, 8'h00, 8'hFF, 8'h00};
      if1.sb_sel = 2'(i);
      #1 chk($sformatf("bad_idx_read%0d", i), 32'(if1.sb_out), 32'(exp_tbl[i]));
    end
    step();
    chk("bad_conflict_end", 32'(if1.conflict), 32'h0);

    // 16-bit bank with a non-default SP reset value.
    if2.adl_en = 1'b1;
    #1 chk("w16_reset_s", 32'(if2.adl_out), 32'h01FF);
    if2.load_en = 1'b1; if2.load_sel = 2'd3; if2.load_data = 16'h0000;
    step();
    if2.load_en = 1'b0; if2.sp_dec = 1'b1;
    step();
    if2.sp_dec = 1'b0;
    chk("w16_dec_s", 32'(if2.adl_out), 32'hFFFF);
    chk("w16_dec_wrap", 32'(if2.sp_wrap), 32'h1);
    rst = 1'b1;
    #1 chk("w16_rst_s", 32'(if2.adl_out), 32'h01FF);
    chk("w16_rst_wrap", 32'(if2.sp_wrap), 32'h0);
    rst = 1'b0;
    model_reset();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
